// File: rtl/intr_flag_ctrl.sv
// Interrupt sequencer: drains the pipe, saves PC/flags, vectors to the ISR, restores on iret.
// Optional round-robin arbitration when INTC_RR_PRIO_EN is defined (fixed priority otherwise).
module intr_flag_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_en,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               pipe_empty,
  input  logic               retire_valid,
  input  logic [31:0]        retire_npc,
  input  logic               gt_flag,
  input  logic               eq_flag,
  input  logic               iret_i,
  output logic               stall_req,
  output logic               flush,
  output logic               pc_redirect_valid,
  output logic [31:0]        pc_redirect,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [2:0]         irq_id,
  output logic               in_isr,
  output logic               iret_flag_valid,
  output logic [1:0]         flag_restore
);

  typedef enum logic [2:0] {IDLE, DRAIN, SAVE, VECTOR, ISR, RESTORE} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] mask, pending;
  logic [31:0]        saved_pc;
  logic [1:0]         shadow;
  logic [2:0]         id_q, win;
  logic               found;

  always_comb pending = irq_in & mask & {NUM_IRQ{int_en}};

`ifdef INTC_RR_PRIO_EN
  logic [2:0] last_id;
  int         rr_idx;

  // Search starts just past the last serviced line and wraps.
  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      rr_idx = (int'(last_id) + 1 + k) % NUM_IRQ;
      if (!found && pending[rr_idx]) begin
        win   = 3'(rr_idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        last_id <= 3'(NUM_IRQ - 1);
    else if (state == SAVE && found) last_id <= win;
  end
`else
  // Descending scan so the lowest pending index is the last write.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win   = 3'(i);
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_nxt         = state;
    stall_req         = 1'b0;
    flush             = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect       = '0;
    irq_ack           = '0;
    in_isr            = 1'b0;
    iret_flag_valid   = 1'b0;
    flag_restore      = '0;
    case (state)
      IDLE: if (|pending) state_nxt = DRAIN;
      DRAIN: begin
        stall_req = 1'b1;
        if (!(|pending))    state_nxt = IDLE;
        else if (pipe_empty) state_nxt = SAVE;
      end
      SAVE: begin
        // A request that vanished during SAVE aborts like a DRAIN abort.
        stall_req = 1'b1;
        for (int i = 0; i < NUM_IRQ; i++) irq_ack[i] = found && (win == 3'(i));
        state_nxt = found ? VECTOR : IDLE;
      end
      VECTOR: begin
        stall_req         = 1'b1;
        flush             = 1'b1;
        pc_redirect_valid = 1'b1;
        pc_redirect       = VEC_BASE + 32'(id_q) * 32'(VEC_STRIDE);
        state_nxt         = ISR;
      end
      ISR: begin
        in_isr = 1'b1;
        if (iret_i) state_nxt = RESTORE;
      end
      RESTORE: begin
        in_isr            = 1'b1;
        iret_flag_valid   = 1'b1;
        flag_restore      = shadow;
        flush             = 1'b1;
        pc_redirect_valid = 1'b1;
        pc_redirect       = saved_pc;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= '1;
      saved_pc <= '0;
      shadow   <= '0;
      id_q     <= '0;
    end else begin
      state <= state_nxt;
      if (mask_we) mask <= mask_wdata;
      if (retire_valid && (state == IDLE || state == DRAIN)) saved_pc <= retire_npc;
      if (state == SAVE && found) begin
        id_q   <= win;
        shadow <= {gt_flag, eq_flag};
      end
    end
  end

  assign irq_id = id_q;

endmodule

// File: tb/tb_intr_flag_ctrl.sv
// Directed self-checking bench for intr_flag_ctrl (default parameters).
module tb_intr_flag_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in, mask_wdata, irq_ack;
  logic        int_en, mask_we, pipe_empty, retire_valid, gt_flag, eq_flag, iret_i;
  logic [31:0] retire_npc, pc_redirect;
  logic        stall_req, flush, pc_redirect_valid, in_isr, iret_flag_valid;
  logic [2:0]  irq_id;
  logic [1:0]  flag_restore;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  intr_flag_ctrl dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .int_en(int_en), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .pipe_empty(pipe_empty), .retire_valid(retire_valid),
    .retire_npc(retire_npc), .gt_flag(gt_flag), .eq_flag(eq_flag), .iret_i(iret_i),
    .stall_req(stall_req), .flush(flush), .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect(pc_redirect), .irq_ack(irq_ack), .irq_id(irq_id), .in_isr(in_isr),
    .iret_flag_valid(iret_flag_valid), .flag_restore(flag_restore)
  );

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nxt; nxt; #2;
    checks++;
    if ({stall_req, flush, pc_redirect_valid, pc_redirect, irq_ack, irq_id, in_isr,
         iret_flag_valid, flag_restore} !== '0) begin
      errors++; $display("FAIL reset_outputs: got stall=%0b pc=%h ack=%b isr=%0b", stall_req, pc_redirect, irq_ack, in_isr);
    end
    nxt; rst = 1'b0;
  endtask

  task automatic test_basic_entry;
    nxt; irq_in = 4'b0100; retire_valid = 1'b1; retire_npc = 32'h3C; gt_flag = 1'b1; eq_flag = 1'b0; #2;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL entry_idle_stall: got %0b exp 0", stall_req); end
    nxt; retire_npc = 32'h40; #2;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL entry_drain_stall: got %0b exp 1", stall_req); end
    nxt; retire_valid = 1'b0; #2;
    checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL entry_drain_noack: got %b exp 0000", irq_ack); end
    nxt; pipe_empty = 1'b1; #2;
    nxt; #2;
    checks++; if (irq_ack !== 4'b0100) begin errors++; $display("FAIL entry_ack: got %b exp 0100", irq_ack); end
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL entry_save_stall: got %0b exp 1", stall_req); end
    nxt; retire_valid = 1'b1; retire_npc = 32'h99; gt_flag = 1'b0; eq_flag = 1'b1; #2;
    checks++; if ({pc_redirect_valid, flush, pc_redirect} !== {2'b11, 32'h120}) begin
      errors++; $display("FAIL entry_vector: got v=%0b f=%0b pc=%h exp 1 1 00000120", pc_redirect_valid, flush, pc_redirect); end
    checks++; if (irq_ack !== 4'b0000) begin errors++; $display("FAIL entry_ack_once: got %b exp 0000", irq_ack); end
    checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL entry_id: got %0d exp 2", irq_id); end
    nxt; retire_valid = 1'b0; irq_in = 4'b0001; #2;
    checks++; if ({in_isr, stall_req, pc_redirect_valid} !== 3'b100) begin
      errors++; $display("FAIL entry_isr: got isr/stall/v=%b exp 100", {in_isr, stall_req, pc_redirect_valid}); end
    nxt; #2;
    checks++; if ({in_isr, stall_req, irq_ack} !== 6'b10_0000) begin
      errors++; $display("FAIL isr_no_nesting: got isr=%0b stall=%0b ack=%b exp 1 0 0000", in_isr, stall_req, irq_ack); end
    nxt; irq_in = 4'b0000; #2;
  endtask

  task automatic test_return;
    nxt; iret_i = 1'b1; #2;
    checks++; if (iret_flag_valid !== 1'b0) begin errors++; $display("FAIL ret_early: got %0b exp 0", iret_flag_valid); end
    nxt; iret_i = 1'b0; #2;
    checks++; if ({iret_flag_valid, flag_restore, pc_redirect_valid, flush, in_isr} !== 6'b1_10_111) begin
      errors++; $display("FAIL ret_strobe: got ifv=%0b fr=%b v=%0b f=%0b isr=%0b exp 1 10 1 1 1",
                         iret_flag_valid, flag_restore, pc_redirect_valid, flush, in_isr); end
    checks++; if (pc_redirect !== 32'h40) begin errors++; $display("FAIL ret_pc: got %h exp 00000040", pc_redirect); end
    nxt; #2;
    checks++; if ({iret_flag_valid, in_isr, pc_redirect_valid} !== 3'b000) begin
      errors++; $display("FAIL ret_idle: got ifv/isr/v=%b exp 000", {iret_flag_valid, in_isr, pc_redirect_valid}); end
  endtask

  task automatic test_simultaneous;
    nxt; irq_in = 4'b0110; #2;
    nxt; #2;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL sim_drain: got %0b exp 1", stall_req); end
    nxt; #2;
    checks++; if (irq_ack !== 4'b0010) begin errors++; $display("FAIL sim_ack1: got %b exp 0010", irq_ack); end
    nxt; irq_in = 4'b0100; #2;
    checks++; if ({irq_id, pc_redirect} !== {3'd1, 32'h110}) begin
      errors++; $display("FAIL sim_vec1: got id=%0d pc=%h exp 1 00000110", irq_id, pc_redirect); end
    nxt; nxt; iret_i = 1'b1; #2;
    nxt; iret_i = 1'b0; #2;
    checks++; if ({iret_flag_valid, flag_restore, pc_redirect} !== {1'b1, 2'b01, 32'h40}) begin
      errors++; $display("FAIL sim_ret1: got ifv=%0b fr=%b pc=%h exp 1 01 00000040", iret_flag_valid, flag_restore, pc_redirect); end
    nxt; #2;
    checks++; if ({stall_req, in_isr} !== 2'b00) begin errors++; $display("FAIL sim_idle_gap: got stall/isr=%b exp 00", {stall_req, in_isr}); end
    nxt; #2;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL sim_drain2: got %0b exp 1", stall_req); end
    nxt; #2;
    checks++; if (irq_ack !== 4'b0100) begin errors++; $display("FAIL sim_ack2: got %b exp 0100", irq_ack); end
    nxt; irq_in = 4'b0000; #2;
    checks++; if ({irq_id, pc_redirect} !== {3'd2, 32'h120}) begin
      errors++; $display("FAIL sim_vec2: got id=%0d pc=%h exp 2 00000120", irq_id, pc_redirect); end
    nxt; nxt; iret_i = 1'b1; #2;
    nxt; iret_i = 1'b0; #2;
    nxt; #2;
  endtask

  task automatic test_masking;
    nxt; mask_we = 1'b1; mask_wdata = 4'b1110; #2;
    nxt; mask_we = 1'b0; irq_in = 4'b0001; #2;
    nxt; #2;
    checks++; if ({stall_req, irq_ack} !== 5'b0) begin errors++; $display("FAIL mask_line: got stall=%0b ack=%b exp 0 0000", stall_req, irq_ack); end
    nxt; #2;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mask_line2: got %0b exp 0", stall_req); end
    nxt; int_en = 1'b0; irq_in = 4'b1111; #2;
    nxt; #2;
    checks++; if ({stall_req, irq_ack} !== 5'b0) begin errors++; $display("FAIL mask_global: got stall=%0b ack=%b exp 0 0000", stall_req, irq_ack); end
    nxt; irq_in = 4'b0000; int_en = 1'b1; mask_we = 1'b1; mask_wdata = 4'b1111; #2;
    nxt; mask_we = 1'b0; #2;
  endtask

  task automatic test_abort;
    nxt; pipe_empty = 1'b0; irq_in = 4'b0001; #2;
    nxt; irq_in = 4'b0000; retire_valid = 1'b1; retire_npc = 32'h200; #2;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL abort_drain: got %0b exp 1", stall_req); end
    nxt; retire_npc = 32'h204; #2;
    checks++; if ({stall_req, irq_ack} !== 5'b0) begin errors++; $display("FAIL abort_idle: got stall=%0b ack=%b exp 0 0000", stall_req, irq_ack); end
    nxt; retire_valid = 1'b0; pipe_empty = 1'b1; irq_in = 4'b1000; #2;
    nxt; #2;
    nxt; #2;
    checks++; if (irq_ack !== 4'b1000) begin errors++; $display("FAIL abort_ack3: got %b exp 1000", irq_ack); end
    nxt; irq_in = 4'b0000; #2;
    checks++; if (pc_redirect !== 32'h130) begin errors++; $display("FAIL abort_vec3: got %h exp 00000130", pc_redirect); end
    nxt; nxt; iret_i = 1'b1; #2;
    nxt; iret_i = 1'b0; #2;
    checks++; if (pc_redirect !== 32'h204) begin errors++; $display("FAIL abort_saved_pc: got %h exp 00000204", pc_redirect); end
    nxt; #2;
  endtask

  task automatic test_reset_isr;
    nxt; irq_in = 4'b0010; #2;
    nxt; nxt; nxt; irq_in = 4'b0000; #2;
    nxt; #2;
    checks++; if (in_isr !== 1'b1) begin errors++; $display("FAIL rst_isr_entry: got %0b exp 1", in_isr); end
    nxt; mask_we = 1'b1; mask_wdata = 4'b0111; #2;
    nxt; mask_we = 1'b0; rst = 1'b1; #2;
    nxt; rst = 1'b0; #2;
    checks++;
    if ({stall_req, flush, pc_redirect_valid, pc_redirect, irq_ack, irq_id, in_isr,
         iret_flag_valid, flag_restore} !== '0) begin
      errors++; $display("FAIL rst_isr_outputs: got isr=%0b id=%0d pc=%h ifv=%0b", in_isr, irq_id, pc_redirect, iret_flag_valid);
    end
    nxt; iret_i = 1'b1; #2;
    nxt; iret_i = 1'b0; #2;
    checks++; if ({iret_flag_valid, pc_redirect_valid, flush} !== 3'b000) begin
      errors++; $display("FAIL rst_isr_iret: got ifv/v/f=%b exp 000", {iret_flag_valid, pc_redirect_valid, flush}); end
    nxt; irq_in = 4'b1000; #2;
    nxt; #2;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL rst_mask_ones: got %0b exp 1", stall_req); end
    nxt; #2;
    checks++; if (irq_ack !== 4'b1000) begin errors++; $display("FAIL rst_mask_ack: got %b exp 1000", irq_ack); end
    nxt; irq_in = 4'b0000; #2;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; int_en = 1'b1; mask_we = 1'b0; mask_wdata = '0;
    pipe_empty = 1'b0; retire_valid = 1'b0; retire_npc = '0; gt_flag = 1'b0;
    eq_flag = 1'b0; iret_i = 1'b0;
    test_reset;
    test_basic_entry;
    test_return;
    test_simultaneous;
    test_masking;
    test_abort;
    test_reset_isr;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_flag_ctrl.md
Name: intr_flag_ctrl

Overview:
- Interrupt sequencer for the SimpleRISC pipeline.
- Arbitrates level-sensitive IRQ lines, stalls and drains the pipeline, and saves the return PC and GT/EQ flags into shadow registers.
- Redirects fetch to the ISR vector.
- On iret, drives the flag unit's restore path (Iret strobe plus saved flag pair) and redirects to the saved PC.
- Sits between the IRQ sources, the fetch/hazard unit and the flag register.

Parameters:
- NUM_IRQ, 4, number of interrupt request lines (2..8).
- VEC_BASE, 32'h0000_0100, vector address of IRQ 0.
- VEC_STRIDE, 16, byte spacing between vectors.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  level interrupt requests.
- int_en  in  1  global interrupt enable.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_IRQ  new mask value; 1 = line enabled.
- pipe_empty  in  1  no valid instruction remains past fetch.
- retire_valid  in  1  an instruction retired this cycle.
- retire_npc  in  32  architectural next-PC of the retiring instruction.
- gt_flag  in  1  current GT flag.
- eq_flag  in  1  current EQ flag.
- iret_i  in  1  iret reached execute (1-cycle pulse).
- stall_req  out  1  freeze fetch.
- flush  out  1  squash younger instructions.
- pc_redirect_valid  out  1  load pc_redirect into PC.
- pc_redirect  out  32  redirect target.
- irq_ack  out  NUM_IRQ  one-hot acknowledge pulse.
- irq_id  out  3  id of the IRQ being serviced.
- in_isr  out  1  handler active.
- iret_flag_valid  out  1  Iret strobe to the flag unit.
- flag_restore  out  2  {GT,EQ} to restore.

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0, except mask = all ones.
  - saved_pc = 0; shadow flags = 2'b00.
  - Reset asserted in any state aborts the sequence immediately; no ack or restore is emitted.
- Mask:
  - mask_we writes the mask on the next edge, in any state.
  - pending = irq_in & mask & {NUM_IRQ{int_en}}.
- saved_pc:
  - Loads retire_npc on every retire_valid cycle while in IDLE or DRAIN.
  - Frozen in all other states.
- FSM states: IDLE, DRAIN, SAVE, VECTOR, ISR, RESTORE.
- IDLE:
  - pending != 0 → DRAIN.
  - iret_i is ignored.
- DRAIN:
  - stall_req = 1.
  - pending == 0 → IDLE (abort: no ack, stall released next cycle).
  - Otherwise pipe_empty = 1 → SAVE.
- SAVE (1 cycle):
  - stall_req = 1.
  - Latch winner id: fixed priority, lowest index wins, evaluated this cycle.
  - Shadow ← {gt_flag, eq_flag}.
  - irq_ack = one-hot(id) for exactly this cycle.
- VECTOR (1 cycle):
  - pc_redirect_valid = 1; flush = 1; stall_req = 1.
  - pc_redirect = VEC_BASE + id*VEC_STRIDE, 32-bit and wrapping.
  - → ISR.
- ISR:
  - in_isr = 1; irq_id held.
  - New or other pending IRQs are not taken (no nesting); they stay pending while the line stays high.
  - iret_i = 1 → RESTORE.
- RESTORE (1 cycle):
  - iret_flag_valid = 1; flag_restore = shadow.
  - pc_redirect_valid = 1; pc_redirect = saved_pc; flush = 1.
  - in_isr = 1 in this cycle.
  - → IDLE.
- Spacing: at least one IDLE cycle between RESTORE and the next DRAIN.
- Ack-to-vector latency is fixed at 1 cycle.

Optional Feature:
- Macro: INTC_RR_PRIO_EN.
- Defined:
  - Arbitration is round-robin.
  - Search starts at (last_serviced_id + 1) mod NUM_IRQ.
  - last_serviced_id updates in SAVE and resets to NUM_IRQ-1, so the first grant after reset favours line 0.
- Undefined: fixed priority, lowest index wins; no extra state.

Test Plan:
1. Basic entry.
   - Stimulus: mask = F, int_en = 1, irq_in = 4'b0100; last retire_npc = 0x40; pipe_empty rises 3 cycles later; GT = 1, EQ = 0.
   - Response: stall_req from the cycle after the IRQ; irq_ack = 0100 for one cycle; next cycle pc_redirect = 0x120 with flush; in_isr = 1.
2. Return.
   - Stimulus: iret_i pulse during ISR from scenario 1.
   - Response: iret_flag_valid = 1 for one cycle, flag_restore = 2'b10, pc_redirect = 0x40, flush = 1; then IDLE, in_isr = 0.
3. Simultaneous requests.
   - Stimulus: irq_in = 0110.
   - Response: irq_id = 1, vector 0x110. After iret, at least one IDLE cycle, then IRQ 2 taken with vector 0x120. With INTC_RR_PRIO_EN, the order is identical from reset.
4. Masking.
   - Stimulus: mask_wdata = 1110 written; irq_in = 0001; or int_en = 0 with irq_in = 1111.
   - Response: stall_req stays 0 and no ack.
5. Abort in DRAIN.
   - Stimulus: irq_in drops to 0 while pipe_empty = 0.
   - Response: returns to IDLE, stall_req deasserted next cycle, no irq_ack, saved_pc keeps tracking retires.
6. Reset during ISR.
   - Stimulus: rst = 1 for one cycle mid-ISR.
   - Response: all outputs 0, mask = F; a later iret_i produces no iret_flag_valid.
